// File: rtl/seq_add_ctrl_pkg.sv
// Shared types and defaults for the bit-serial adder controller.
package seq_add_pkg;

  localparam int DEF_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/seq_add_ctrl_if.sv
// Start/busy/done handshake bundle between a requester and the serial adder.
interface seq_add_if
  import seq_add_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
);

  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (
    output start, a, b, cin,
    input  busy, done, sum, cout, ovf
  );

  modport slave (
    input  start, a, b, cin,
    output busy, done, sum, cout, ovf
  );

endinterface

// File: rtl/seq_add_ctrl_fa_cell.sv
// Single combinational full-adder cell reused every cycle by the serial adder.
module fa_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/seq_add_ctrl.sv
// Bit-serial adder: one full-adder cell over WIDTH cycles, LSB first.
// Optional signed-overflow flag built only when SEQ_ADD_OVF_EN is defined.
module seq_add_ctrl
  import seq_add_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic     clk,
  input  logic     rst,
  seq_add_if.slave bus
);

  localparam int              CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] sum_q;
  logic             carry;
  logic             cout_q;
  logic             busy_q;
  logic             done_q;
  logic [CNT_W-1:0] cnt;
  logic             fa_s;
  logic             fa_co;
  logic             accept;
  logic             last_bit;

  // start is honoured only outside RUN; a request mid-operation is dropped.
  assign accept   = ((state == IDLE) || (state == DONE)) && bus.start;
  assign last_bit = (state == RUN) && (cnt == LAST);

  fa_cell u_fa (
    .a    (a_sh[0]),
    .b    (b_sh[0]),
    .cin  (carry),
    .s    (fa_s),
    .cout (fa_co)
  );

  // NOTE: state is updated with non-blocking assignments so every flop samples
  // pre-edge values; reset is synchronous, so it lives inside the clocked block.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      a_sh   <= '0;
      b_sh   <= '0;
      sum_q  <= '0;
      carry  <= 1'b0;
      cout_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      cnt    <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done_q <= 1'b0;
          if (accept) begin
            state  <= RUN;
            busy_q <= 1'b1;
            a_sh   <= bus.a;
            b_sh   <= bus.b;
            carry  <= bus.cin;
            cnt    <= '0;
            sum_q  <= '0;
            cout_q <= 1'b0;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          a_sh  <= a_sh >> 1;
          b_sh  <= b_sh >> 1;
          sum_q <= {fa_s, sum_q[WIDTH-1:1]};
          carry <= fa_co;
          if (last_bit) begin
            // Counter is parked at zero here rather than left to wrap on its own.
            cnt    <= '0;
            state  <= DONE;
            busy_q <= 1'b0;
            done_q <= 1'b1;
            cout_q <= fa_co;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
          done_q <= 1'b0;
        end
      endcase
    end
  end

`ifdef SEQ_ADD_OVF_EN
  // Carry into the MSB; XOR with the final carry-out gives signed overflow.
  logic c_msb;

  always_ff @(posedge clk) begin
    if (rst || accept) begin
      c_msb <= 1'b0;
    end else if (last_bit) begin
      c_msb <= carry;
    end
  end

  assign bus.ovf = c_msb ^ cout_q;
`else
  assign bus.ovf = 1'b0;
`endif

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;

endmodule

// File: tb/tb_seq_add_ctrl.sv
// Self-checking bench for seq_add_ctrl: directed cases plus random traffic against an arithmetic model.
module tb_seq_add_ctrl;

  localparam int W = 4;
`ifdef SEQ_ADD_OVF_EN
  localparam bit OVF_ON = 1'b1;
`else
  localparam bit OVF_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;

  seq_add_if #(.WIDTH(W)) bus ();

  seq_add_ctrl #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Arithmetic reference: result is a+b+cin; during the run, the k low result
  // bits already produced sit at the top of sum.
  bit           m_valid = 1'b0;
  bit           m_busy, m_done, m_cout, m_ovf, m_res_ovf;
  int           m_steps;
  logic [W:0]   m_res;
  logic [W-1:0] m_sum, m_lo;

  always @(posedge clk) begin
    if (rst) begin
      m_valid = 1'b1;
      m_busy  = 1'b0;
      m_done  = 1'b0;
      m_sum   = '0;
      m_cout  = 1'b0;
      m_ovf   = 1'b0;
      m_steps = 0;
    end else if (m_valid) begin
      if (m_busy) begin
        m_steps++;
        m_lo  = m_res[W-1:0];
        m_sum = m_lo << (W - m_steps);
        if (m_steps == W) begin
          m_busy = 1'b0;
          m_done = 1'b1;
          m_cout = m_res[W];
          m_ovf  = m_res_ovf;
        end
      end else if (bus.start) begin
        m_res     = {1'b0, bus.a} + {1'b0, bus.b} + {{W{1'b0}}, bus.cin};
        m_res_ovf = OVF_ON && (bus.a[W-1] == bus.b[W-1]) && (m_res[W-1] != bus.a[W-1]);
        m_busy    = 1'b1;
        m_done    = 1'b0;
        m_steps   = 0;
        m_sum     = '0;
        m_cout    = 1'b0;
        m_ovf     = 1'b0;
      end else begin
        m_done = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      check("model_busy", 32'(bus.busy), 32'(m_busy));
      check("model_done", 32'(bus.done), 32'(m_done));
      check("model_sum",  32'(bus.sum),  32'(m_sum));
      check("model_cout", 32'(bus.cout), 32'(m_cout));
      check("model_ovf",  32'(bus.ovf),  32'(m_ovf));
    end
  end

  // Pulses start for one cycle; returns at the negedge of cycle 1 with garbage on the operand inputs.
  task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin);
    @(negedge clk);
    bus.start = 1'b1;
    bus.a     = a;
    bus.b     = b;
    bus.cin   = cin;
    @(negedge clk);
    bus.start = 1'b0;
    bus.a     = W'($urandom);
    bus.b     = W'($urandom);
    bus.cin   = 1'($urandom);
  endtask

  // Waits (bounded) from cycle 1 until done; reports busy cycles seen and done cycle index.
  task automatic wait_done(output int busy_n, output int done_at);
    int cyc = 1;
    busy_n  = 0;
    done_at = -1;
    while (cyc < 3 * W + 6) begin
      if (bus.done) begin
        done_at = cyc;
        break;
      end
      if (bus.busy) busy_n++;
      @(negedge clk);
      cyc++;
    end
    if (done_at < 0) check("done_timeout", 32'(0), 32'(1));
  endtask

  task automatic op_expect(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic cin, input logic [W-1:0] e_sum, input logic e_cout,
                           input logic e_ovf);
    int bn, da;
    start_op(a, b, cin);
    wait_done(bn, da);
    check({name, "_sum"},  32'(bus.sum),  32'(e_sum));
    check({name, "_cout"}, 32'(bus.cout), 32'(e_cout));
    check({name, "_ovf"},  32'(bus.ovf),  32'(e_ovf & OVF_ON));
  endtask

  initial begin
    int bn, da, pulses;
    logic [W-1:0] seen_sum;
    logic         seen_cout;

    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    bus.cin   = 1'b0;

    // Reset state.
    repeat (2) @(negedge clk);
    check("rst_busy", 32'(bus.busy), 32'(0));
    check("rst_done", 32'(bus.done), 32'(0));
    check("rst_sum",  32'(bus.sum),  32'(0));
    check("rst_cout", 32'(bus.cout), 32'(0));
    check("rst_ovf",  32'(bus.ovf),  32'(0));
    rst = 1'b0;

    // Basic timing: 5+3.
    start_op(4'h5, 4'h3, 1'b0);
    wait_done(bn, da);
    check("basic_busy_cycles", 32'(bn), 32'(4));
    check("basic_done_cycle",  32'(da), 32'(5));
    check("basic_sum",  32'(bus.sum),  32'(8));
    check("basic_cout", 32'(bus.cout), 32'(0));
    check("basic_ovf",  32'(bus.ovf),  32'(OVF_ON));
    @(negedge clk);
    check("basic_done_one_cycle", 32'(bus.done), 32'(0));
    check("basic_sum_held", 32'(bus.sum), 32'(8));

    // Wrap-around.
    op_expect("wrap1", 4'hF, 4'h1, 1'b0, 4'h0, 1'b1, 1'b0);
    op_expect("wrap2", 4'hF, 4'hF, 1'b1, 4'hF, 1'b1, 1'b0);

    // start during RUN is ignored.
    start_op(4'h2, 4'h2, 1'b0);
    @(negedge clk);
    bus.start = 1'b1;
    bus.a     = 4'h9;
    bus.b     = 4'h9;
    @(negedge clk);
    bus.start = 1'b0;
    pulses    = 0;
    seen_sum  = '0;
    seen_cout = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (bus.done) begin
        pulses++;
        seen_sum  = bus.sum;
        seen_cout = bus.cout;
      end
      @(negedge clk);
    end
    check("ignore_pulses", 32'(pulses),    32'(1));
    check("ignore_sum",    32'(seen_sum),  32'(4));
    check("ignore_cout",   32'(seen_cout), 32'(0));

    // Reset in cycle 2 of RUN.
    start_op(4'hA, 4'h3, 1'b1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_busy", 32'(bus.busy), 32'(0));
    check("abort_done", 32'(bus.done), 32'(0));
    check("abort_sum",  32'(bus.sum),  32'(0));
    op_expect("after_abort", 4'h6, 4'h7, 1'b1, 4'hE, 1'b0, 1'b1);

    // Back-to-back: new start accepted in the DONE cycle.
    start_op(4'h1, 4'h1, 1'b0);
    wait_done(bn, da);
    check("b2b_first_sum", 32'(bus.sum), 32'(2));
    bus.start = 1'b1;
    bus.a     = 4'h8;
    bus.b     = 4'h8;
    bus.cin   = 1'b0;
    @(negedge clk);
    bus.start = 1'b0;
    check("b2b_busy_rises", 32'(bus.busy), 32'(1));
    wait_done(bn, da);
    check("b2b_second_sum",  32'(bus.sum),  32'(0));
    check("b2b_second_cout", 32'(bus.cout), 32'(1));
    check("b2b_second_ovf",  32'(bus.ovf),  32'(OVF_ON));

    // Overflow cases.
    op_expect("ovf_7p1", 4'h7, 4'h1, 1'b0, 4'h8, 1'b0, 1'b1);
    op_expect("ovf_8p8", 4'h8, 4'h8, 1'b0, 4'h0, 1'b1, 1'b1);
    op_expect("ovf_3p2", 4'h3, 4'h2, 1'b0, 4'h5, 1'b0, 1'b0);

    // Random traffic, including mid-run starts and occasional resets.
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      rst       = ($urandom_range(0, 59) == 0);
      bus.start = ($urandom_range(0, 3) == 0);
      bus.a     = W'($urandom);
      bus.b     = W'($urandom);
      bus.cin   = 1'($urandom);
    end
    @(negedge clk);
    rst       = 1'b0;
    bus.start = 1'b0;
    repeat (W + 3) @(negedge clk);

    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

endmodule
